// File: rtl/fifo_memory_based.sv
// Memory-based synchronous FIFO.
// Storage is a FIFO_DEPTH x DATA_WIDTH array addressed by separate write and
// read pointers; an occupancy counter drives the full/empty flags. Read data
// is registered, so a word appears on dout one edge after its read is taken.
// FIFO_DEPTH does not need to be a power of two: pointers wrap explicitly.
module fifo_memory_based #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] EMPTY_CNT = '0;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic rd_accept;
  logic wr_accept;

  // Flags come straight from the registered occupancy.
  assign full  = (count == FULL_CNT);
  assign empty = (count == EMPTY_CNT);

  // A read needs data present; a write needs room, where a same-cycle read
  // counts as freeing one slot so a full FIFO can stream.
  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | rd_accept);

  // Pointer advance with explicit wrap at the last entry.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_accept) begin
      if (wr_ptr == LAST_PTR) begin
        wr_ptr_next = '0;
      end else begin
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
    end
    if (rd_accept) begin
      if (rd_ptr == LAST_PTR) begin
        rd_ptr_next = '0;
      end else begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy moves only when exactly one of read/write is taken.
  always_comb begin
    count_next = count;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; never reset, stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Registered read data; reads the old word even when a write hits the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (rd_accept) begin
      dout <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fifo_memory_based.sv
// Self-checking bench for fifo_memory_based (default 8 x 8).
// A queue-based model tracks expected contents and dout; a negedge process
// compares the DUT against it every cycle, and directed steps pin key values.
module tb_fifo_memory_based;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  logic [7:0] mDout;
  bit         modelValid = 0;

  localparam int DEPTH = 8;

  fifo_memory_based #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: one line per mismatch.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic r, input logic w, input logic rd,
                               input logic [7:0] d);
    bit rdOk;
    bit wrOk;
    rst   = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      mDout = 8'h00;
    end else begin
      rdOk = rd && (q.size() != 0);
      wrOk = w && ((q.size() < DEPTH) || rdOk);
      if (rdOk) mDout = q.pop_front();
      if (wrOk) q.push_back(d);
    end
    #1;
    modelValid = 1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cyc_dout", dout, mDout);
      checkOutput("cyc_full", {7'd0, full}, {7'd0, q.size() == DEPTH});
      checkOutput("cyc_empty", {7'd0, empty}, {7'd0, q.size() == 0});
    end
  end

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    mDout = 8'h00;

    // Reset with idle inputs.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    checkOutput("lit_reset_empty", {7'd0, empty}, 8'h01);
    checkOutput("lit_reset_full", {7'd0, full}, 8'h00);
    checkOutput("lit_reset_dout", dout, 8'h00);

    // Fill with 0x11..0x88, then one ignored write while full.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i * 8'h11));
    end
    checkOutput("lit_full_after8", {7'd0, full}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h99);
    checkOutput("lit_full_after9", {7'd0, full}, 8'h01);

    // Drain in order, then one read on empty.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      checkOutput("lit_drain_dout", dout, 8'(i * 8'h11));
    end
    checkOutput("lit_drain_empty", {7'd0, empty}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("lit_empty_read_hold", dout, 8'h88);

    // Four entries, then simultaneous read/write.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hB0);
    checkOutput("lit_rw_dout", dout, 8'hA0);
    checkOutput("lit_rw_empty", {7'd0, empty}, 8'h00);
    checkOutput("lit_rw_full", {7'd0, full}, 8'h00);

    // Top up to full, then simultaneous read/write at full.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    end
    checkOutput("lit_topup_full", {7'd0, full}, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hD0);
    checkOutput("lit_full_rw_dout", dout, 8'hA1);
    checkOutput("lit_full_rw_full", {7'd0, full}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("lit_full_rw_last", dout, 8'hD0);
    checkOutput("lit_full_rw_empty", {7'd0, empty}, 8'h01);

    // Write to empty with read asserted: write only.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("lit_wr_empty_dout", dout, 8'hD0);
    checkOutput("lit_wr_empty_flag", {7'd0, empty}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("lit_wr_empty_read", dout, 8'h5A);

    // Mid-operation reset discards entries.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lit_midrst_empty", {7'd0, empty}, 8'h01);
    checkOutput("lit_midrst_dout", dout, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hC3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("lit_midrst_read", dout, 8'hC3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("lit_midrst_stale", dout, 8'hC3);

    // Streaming with pointer wrap: 20 writes, reads from the fourth cycle on.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, (i >= 3), 8'(8'h30 + i));
    end
    checkOutput("lit_wrap_dout", dout, 8'h40);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("lit_wrap_tail", dout, 8'h43);
    checkOutput("lit_wrap_empty", {7'd0, empty}, 8'h01);

    // A few idle cycles so the per-cycle checker sees the settled state.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
